// File: rtl/vlsu_seq.sv
// Vector load/store sequencer: walks strided word addresses for one command at a time,
// issuing reads toward the VRF write-back or writing elements taken from the VRF read stream.
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | waiting for a command, cmd_ready_o high
// S_LOAD       | one read issue per cycle, len issues back to back
// S_LOAD_DRAIN | no issue; last load element is being presented
// S_STORE      | one write per accepted st_valid_i, stalls when it is low
// S_DONE       | one-cycle completion pulse, next command the cycle after
module vlsu_seq #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_store_i,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [ADDR_W-1:0] cmd_stride_i,
  input  logic [CNT_W-1:0]  cmd_len_i,
  output logic [ADDR_W-1:0] mem_ra_o,
  input  logic [DATA_W-1:0] mem_rd_i,
  output logic [ADDR_W-1:0] mem_wa_o,
  output logic [DATA_W-1:0] mem_wd_o,
  output logic              mem_we_o,
  output logic              ld_valid_o,
  output logic [CNT_W-1:0]  ld_idx_o,
  output logic [DATA_W-1:0] ld_data_o,
  input  logic              st_valid_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic              st_ready_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_LOAD_DRAIN = 3'd2;
  localparam logic [2:0] S_STORE      = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic              ld_valid_q, ld_valid_d;
  logic [CNT_W-1:0]  ld_idx_q, ld_idx_d;

  logic issue;
  logic st_fire;
  logic last_elem;

  assign issue     = (state_q == S_LOAD);
  assign st_fire   = (state_q == S_STORE) && st_valid_i;
  assign last_elem = (cnt_q == (len_q - CNT_W'(1)));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ra_d       = issue ? addr_q : ra_q;
    ld_valid_d = issue;
    ld_idx_d   = issue ? cnt_q : ld_idx_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d   = cmd_base_i;
          stride_d = cmd_stride_i;
          len_d    = cmd_len_i;
          cnt_d    = '0;
          if (cmd_len_i == '0) begin
            state_d = S_DONE;
          end else if (cmd_store_i) begin
            state_d = S_STORE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // Two's-complement add handles negative strides; wrap is intended.
        addr_d = addr_q + stride_q;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_elem) begin
          state_d = S_LOAD_DRAIN;
        end
      end
      S_LOAD_DRAIN: begin
        state_d = S_DONE;
      end
      S_STORE: begin
        if (st_valid_i) begin
          addr_d = addr_q + stride_q;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_elem) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      ra_q       <= '0;
      ld_valid_q <= 1'b0;
      ld_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ra_q       <= ra_d;
      ld_valid_q <= ld_valid_d;
      ld_idx_q   <= ld_idx_d;
    end
  end

  // Read address is live while issuing and otherwise holds the last issued address.
  assign mem_ra_o    = issue ? addr_q : ra_q;
  assign mem_we_o    = st_fire;
  assign mem_wa_o    = addr_q;
  assign mem_wd_o    = st_data_i;
  assign ld_valid_o  = ld_valid_q;
  assign ld_idx_o    = ld_idx_q;
  assign ld_data_o   = mem_rd_i;
  assign st_ready_o  = (state_q == S_STORE);
  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_vlsu_seq.sv
// Bench for vlsu_seq: memory emulator, transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized commands.
module tb_vlsu_seq;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_store;
  logic [31:0] cmd_base, cmd_stride;
  logic [11:0] cmd_len;
  logic [31:0] mem_ra, mem_wa;
  logic [63:0] mem_rd, mem_wd;
  logic        mem_we;
  logic        ld_valid;
  logic [11:0] ld_idx;
  logic [63:0] ld_data;
  logic        st_valid, st_ready;
  logic [63:0] st_data;
  logic        busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vlsu_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_store_i(cmd_store),
    .cmd_base_i(cmd_base), .cmd_stride_i(cmd_stride), .cmd_len_i(cmd_len),
    .mem_ra_o(mem_ra), .mem_rd_i(mem_rd), .mem_wa_o(mem_wa), .mem_wd_o(mem_wd),
    .mem_we_o(mem_we), .ld_valid_o(ld_valid), .ld_idx_o(ld_idx), .ld_data_o(ld_data),
    .st_valid_i(st_valid), .st_data_i(st_data), .st_ready_o(st_ready),
    .busy_o(busy), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory emulator: registered read, write on the clock edge; unwritten words read a*0x11.
  logic [63:0] em [logic [31:0]];
  function automatic logic [63:0] emval(input logic [31:0] a);
    if (em.exists(a)) return em[a];
    return 64'(a) * 64'h11;
  endfunction
  always @(posedge clk) begin
    mem_rd <= emval(mem_ra);
    if (mem_we) em[mem_wa] = mem_wd;
  end

  // Reference model: one command at a time, expectations derived from element position.
  logic [63:0] mm [logic [31:0]];
  int          m_act = 0;   // 0 idle, 1 load, 2 store, 3 empty command
  int          m_k, m_wr, m_len;
  logic [31:0] m_base, m_stride, m_ra;
  logic        e_ready, e_busy, e_done, e_ldv, e_we, e_str;
  logic [31:0] e_ra, e_wa;
  logic [63:0] e_ld, e_wd;
  logic [11:0] e_idx;
  logic [63:0] ld_log[$];
  logic [31:0] ra_log[$];
  logic [11:0] idx_log[$];
  int ldv_cnt = 0, we_cnt = 0, done_cnt = 0;

  function automatic logic [63:0] mval(input logic [31:0] a);
    if (mm.exists(a)) return mm[a];
    return 64'(a) * 64'h11;
  endfunction
  function automatic logic [31:0] ea(input int i);
    return m_base + m_stride * 32'(i);
  endfunction

  always @(negedge clk) begin
    if (ld_valid) ldv_cnt++;
    if (mem_we) we_cnt++;
    if (done) done_cnt++;
    if (rst) begin
      m_act = 0;
      m_ra  = '0;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ld_valid", 64'(ld_valid), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_st_ready", 64'(st_ready), 64'd0);
      chk("rst_mem_ra", 64'(mem_ra), 64'd0);
      chk("rst_ld_idx", 64'(ld_idx), 64'd0);
    end else begin
      e_ready = 0; e_busy = 1; e_done = 0; e_ldv = 0; e_we = 0; e_str = 0;
      e_ra = m_ra; e_wa = '0; e_wd = '0; e_ld = '0; e_idx = '0;
      case (m_act)
        0: begin
          e_ready = 1; e_busy = 0;
          if (cmd_valid) begin
            m_base = cmd_base; m_stride = cmd_stride; m_len = int'(cmd_len);
            m_k = 0; m_wr = 0;
            m_act = (cmd_len == 0) ? 3 : (cmd_store ? 2 : 1);
          end
        end
        1: begin
          m_k++;
          if (m_k <= m_len) begin
            e_ra = ea(m_k - 1);
            m_ra = e_ra;
            ra_log.push_back(mem_ra);
          end
          if (m_k >= 2 && m_k <= m_len + 1) begin
            e_ldv = 1;
            e_idx = 12'(m_k - 2);
            e_ld  = mval(ea(m_k - 2));
          end
          if (m_k == m_len + 2) begin
            e_done = 1;
            m_act = 0;
          end
        end
        2: begin
          if (m_wr < m_len) begin
            e_str = 1;
            if (st_valid) begin
              e_we = 1;
              e_wa = ea(m_wr);
              e_wd = st_data;
              mm[e_wa] = st_data;
              m_wr++;
            end
          end else begin
            e_done = 1;
            m_act = 0;
          end
        end
        default: begin
          e_done = 1;
          m_act = 0;
        end
      endcase
      chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("ld_valid", 64'(ld_valid), 64'(e_ldv));
      chk("mem_we", 64'(mem_we), 64'(e_we));
      chk("st_ready", 64'(st_ready), 64'(e_str));
      chk("mem_ra", 64'(mem_ra), 64'(e_ra));
      if (e_ldv) begin
        chk("ld_idx", 64'(ld_idx), 64'(e_idx));
        chk("ld_data", ld_data, e_ld);
        ld_log.push_back(ld_data);
        idx_log.push_back(ld_idx);
      end
      if (e_we) begin
        chk("mem_wa", 64'(mem_wa), 64'(e_wa));
        chk("mem_wd", mem_wd, e_wd);
      end
    end
  end

  task automatic send(input logic st, input logic [31:0] b, input logic [31:0] s,
                      input logic [11:0] l, output int acc);
    cmd_store = st; cmd_base = b; cmd_stride = s; cmd_len = l; cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (acc < 0) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic wait_done(input bit rnd, output int dc);
    dc = -1;
    for (int i = 0; i < 300; i++) begin
      if (rnd) begin
        st_valid = 1'($urandom_range(0, 1));
        st_data  = {$urandom, $urandom};
      end
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    if (dc < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int acc, acc2, dc, we0, ldv0, dn0;
    logic [63:0] da, db, dcv;
    bit pat [5];
    rst = 1'b1; cmd_valid = 0; cmd_store = 0; cmd_base = '0; cmd_stride = '0;
    cmd_len = '0; st_valid = 0; st_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Plain load
    ld_log.delete(); ra_log.delete();
    send(0, 32'h10, 32'd1, 12'd4, acc);
    wait_done(0, dc);
    chk("t1_done_latency", 64'(dc - acc), 64'd6);
    chk("t1_ra_count", 64'(ra_log.size()), 64'd4);
    chk("t1_ld_count", 64'(ld_log.size()), 64'd4);
    if (ra_log.size() == 4 && ld_log.size() == 4) begin
      chk("t1_ra0", 64'(ra_log[0]), 64'h10);
      chk("t1_ra3", 64'(ra_log[3]), 64'h13);
      chk("t1_ld0", ld_log[0], 64'h110);
      chk("t1_ld1", ld_log[1], 64'h121);
      chk("t1_ld2", ld_log[2], 64'h132);
      chk("t1_ld3", ld_log[3], 64'h143);
    end

    // Store with gaps, negative stride
    da = 64'hA0A0_0000_1111_0001; db = 64'hB0B0_0000_2222_0002; dcv = 64'hC0C0_0000_3333_0003;
    pat = '{1, 0, 1, 0, 1};
    we0 = we_cnt;
    send(1, 32'h100, 32'hFFFF_FFFE, 12'd3, acc);
    for (int i = 0; i < 5; i++) begin
      st_valid = pat[i];
      st_data  = (i == 0) ? da : (i == 2) ? db : (i == 4) ? dcv : 64'hDEAD_BEEF_DEAD_BEEF;
      @(posedge clk); #1;
    end
    st_valid = 0;
    wait_done(0, dc);
    chk("t2_done_latency", 64'(dc - acc), 64'd6);
    chk("t2_we_count", 64'(we_cnt - we0), 64'd3);
    chk("t2_mem_100", emval(32'h100), da);
    chk("t2_mem_fe", emval(32'hFE), db);
    chk("t2_mem_fc", emval(32'hFC), dcv);
    ld_log.delete();
    send(0, 32'h100, 32'hFFFF_FFFE, 12'd3, acc);
    wait_done(0, dc);
    chk("t2_rb_count", 64'(ld_log.size()), 64'd3);
    if (ld_log.size() == 3) begin
      chk("t2_rb0", ld_log[0], da);
      chk("t2_rb1", ld_log[1], db);
      chk("t2_rb2", ld_log[2], dcv);
    end

    // Empty commands
    we0 = we_cnt; ldv0 = ldv_cnt;
    send(0, 32'h55, 32'd1, 12'd0, acc);
    wait_done(0, dc);
    chk("t3_load0_latency", 64'(dc - acc), 64'd1);
    send(1, 32'h66, 32'd1, 12'd0, acc);
    st_valid = 1; st_data = 64'h1234;
    wait_done(0, dc);
    chk("t3_store0_latency", 64'(dc - acc), 64'd1);
    chk("t3_no_we", 64'(we_cnt - we0), 64'd0);
    chk("t3_no_ldv", 64'(ldv_cnt - ldv0), 64'd0);

    // Address wrap
    ra_log.delete(); idx_log.delete();
    send(0, 32'hFFFF_FFFF, 32'd1, 12'd2, acc);
    wait_done(0, dc);
    chk("t4_ra_count", 64'(ra_log.size()), 64'd2);
    chk("t4_idx_count", 64'(idx_log.size()), 64'd2);
    if (ra_log.size() == 2 && idx_log.size() == 2) begin
      chk("t4_ra0", 64'(ra_log[0]), 64'hFFFF_FFFF);
      chk("t4_ra1", 64'(ra_log[1]), 64'h0);
      chk("t4_idx0", 64'(idx_log[0]), 64'd0);
      chk("t4_idx1", 64'(idx_log[1]), 64'd1);
    end

    // Reset in the middle of a load
    dn0 = done_cnt;
    send(0, 32'h40, 32'd3, 12'd8, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_busy_async", 64'(busy), 64'd0);
    chk("t5_ldv_async", 64'(ld_valid), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ready_after", 64'(cmd_ready), 64'd1);
    chk("t5_no_done", 64'(done_cnt - dn0), 64'd0);
    @(posedge clk); #1;
    send(0, 32'h200, 32'd5, 12'd1, acc);
    wait_done(0, dc);
    chk("t5_len1_latency", 64'(dc - acc), 64'd3);

    // Back-to-back with cmd_valid held
    idx_log.delete();
    cmd_store = 0; cmd_base = 32'h300; cmd_stride = 32'd1; cmd_len = 12'd2; cmd_valid = 1;
    acc = -1; acc2 = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = cyc; break; end
    end
    @(posedge clk); #1;
    cmd_base = 32'h400;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc2 = cyc; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("t6_second_accept", 64'(acc2 - acc), 64'd5);
    wait_done(0, dc);
    chk("t6_idx_count", 64'(idx_log.size()), 64'd4);
    if (idx_log.size() == 4) begin
      chk("t6_idx2", 64'(idx_log[2]), 64'd0);
      chk("t6_idx3", 64'(idx_log[3]), 64'd1);
    end

    // Randomized commands
    for (int n = 0; n < 60; n++) begin
      logic        rs;
      logic [31:0] rb, rstr;
      logic [11:0] rl;
      rs   = 1'($urandom_range(0, 1));
      rb   = (n % 3 == 0) ? $urandom : 32'($urandom_range(0, 31));
      rstr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
      rl   = 12'($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(rs, rb, rstr, rl, acc);
      wait_done(rs, dc);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
